// File: rtl/taintcell_mem_tracked.sv
// rtl/taintcell_mem_tracked.sv - shadow taint store for a multi-port memory with a tracked tainted-word count
//
// Purpose: keeps one taint bit per data bit of a shadowed memory. Reads return the taint of the
//   addressed word, registered or combinational. Write taint comes from the data, the address and
//   the per-bit enable. taint_sum counts the words that have any taint bit set. It is updated
//   incrementally from the words each write touches.
// Ports:
//   CLK, reset                      clock (rising edge), synchronous active-high reset
//   RD_EN / RD_EN_taint             per-read-port enable and its taint
//   RD_ADDR / RD_ADDR_taint         packed read addresses and their taint
//   RD_DATA_taint                   packed read data taint
//   WR_EN / WR_EN_taint             packed per-bit write enables and their taint
//   WR_ADDR / WR_ADDR_taint         packed write addresses and their taint
//   WR_DATA_taint                   packed write data taint
//   taint_sum                       registered count of words with any taint bit set
// Optional: macro TAINTCELL_MEM_TRACE_EN adds taint_first_valid / taint_first_addr. These record
//   the address of the first word that becomes tainted after reset.
module taintcell_mem_tracked #(
  parameter int SIZE       = 4,
  parameter int OFFSET     = 0,
  parameter int ABITS      = 2,
  parameter int WIDTH      = 8,
  parameter int RD_PORTS   = 1,
  parameter int WR_PORTS   = 1,
  parameter int RD_LATENCY = 1,
  parameter logic [RD_PORTS-1:0] RD_TRANSPARENT = '0
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [RD_PORTS-1:0]       RD_EN,
  input  logic [RD_PORTS-1:0]       RD_EN_taint,
  input  logic [RD_PORTS*ABITS-1:0] RD_ADDR,
  input  logic [RD_PORTS*ABITS-1:0] RD_ADDR_taint,
  output logic [RD_PORTS*WIDTH-1:0] RD_DATA_taint,
  input  logic [WR_PORTS*WIDTH-1:0] WR_EN,
  input  logic [WR_PORTS*WIDTH-1:0] WR_EN_taint,
  input  logic [WR_PORTS*ABITS-1:0] WR_ADDR,
  input  logic [WR_PORTS*ABITS-1:0] WR_ADDR_taint,
  input  logic [WR_PORTS*WIDTH-1:0] WR_DATA_taint,
  output logic [ABITS:0]            taint_sum
`ifdef TAINTCELL_MEM_TRACE_EN
  ,
  output logic                      taint_first_valid,
  output logic [ABITS-1:0]          taint_first_addr
`endif
);

  localparam logic [ABITS:0]   OFF_W  = (ABITS+1)'(OFFSET);
  localparam logic [ABITS:0]   SIZE_W = (ABITS+1)'(SIZE);
  localparam logic [ABITS-1:0] OFF_A  = ABITS'(OFFSET);

  function automatic logic in_range(input logic [ABITS-1:0] a);
    logic [ABITS:0] ax;
    ax = {1'b0, a};
    return (ax >= OFF_W) && ((ax - OFF_W) < SIZE_W);
  endfunction

  logic [WIDTH-1:0] shadow    [SIZE];
  logic [WIDTH-1:0] shadow_nx [SIZE];

  logic [WR_PORTS-1:0]            wr_ok;   // address maps onto a real word
  logic [WR_PORTS-1:0]            wr_act;  // in range and touches at least one bit
  logic [WR_PORTS-1:0]            wr_at;   // any address bit tainted
  logic [WR_PORTS-1:0][ABITS-1:0] wr_idx;
  logic [ABITS:0]                 rises;
  logic [ABITS:0]                 falls;

  logic [RD_PORTS-1:0][WIDTH-1:0] rd_val;     // from pre-write shadow
  logic [RD_PORTS-1:0][WIDTH-1:0] rd_val_tr;  // from post-write shadow (transparent ports)

  always_comb begin
    for (int p = 0; p < WR_PORTS; p++) begin
      wr_ok[p]  = in_range(WR_ADDR[p*ABITS +: ABITS]);
      wr_idx[p] = WR_ADDR[p*ABITS +: ABITS] - OFF_A;
      wr_at[p]  = |WR_ADDR_taint[p*ABITS +: ABITS];
      wr_act[p] = wr_ok[p] && |(WR_EN[p*WIDTH +: WIDTH] | WR_EN_taint[p*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    for (int w = 0; w < SIZE; w++) shadow_nx[w] = shadow[w];
    // Ascending port order so the highest port index has the last word on a shared bit.
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_ok[p]) begin
        for (int j = 0; j < WIDTH; j++) begin
          if (WR_EN[p*WIDTH+j])
            shadow_nx[wr_idx[p]][j] = WR_DATA_taint[p*WIDTH+j] | wr_at[p] | WR_EN_taint[p*WIDTH+j];
          else if (WR_EN_taint[p*WIDTH+j])
            shadow_nx[wr_idx[p]][j] = 1'b1;  // enable might have been 1: assume the bit got tainted
        end
      end
    end
    // Word-level transitions only for touched words, each word credited to its highest active port.
    rises = '0;
    falls = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      logic dup;
      dup = 1'b0;
      for (int q = p + 1; q < WR_PORTS; q++)
        if (wr_act[q] && (wr_idx[q] == wr_idx[p])) dup = 1'b1;
      if (wr_act[p] && !dup) begin
        if (!(|shadow[wr_idx[p]]) && (|shadow_nx[wr_idx[p]])) rises = rises + 1'b1;
        if ((|shadow[wr_idx[p]]) && !(|shadow_nx[wr_idx[p]])) falls = falls + 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      logic [ABITS-1:0] ra;
      logic [WIDTH-1:0] at;
      ra = RD_ADDR[p*ABITS +: ABITS];
      at = {WIDTH{|RD_ADDR_taint[p*ABITS +: ABITS]}};
      if (in_range(ra)) begin
        rd_val[p]    = shadow[ra - OFF_A] | at;
        rd_val_tr[p] = shadow_nx[ra - OFF_A] | at;
      end else begin
        rd_val[p]    = '1;
        rd_val_tr[p] = '1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int w = 0; w < SIZE; w++) shadow[w] <= '0;
      taint_sum <= '0;
    end else begin
      for (int w = 0; w < SIZE; w++) shadow[w] <= shadow_nx[w];
      taint_sum <= taint_sum + rises - falls;
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_rd_comb
      assign RD_DATA_taint = rd_val;
      logic unused_rd;
      assign unused_rd = &{1'b0, RD_EN, RD_EN_taint, rd_val_tr};
    end else begin : g_rd_reg
      logic [RD_PORTS-1:0][WIDTH-1:0] rd_q;
      always_ff @(posedge CLK) begin
        if (reset) begin
          rd_q <= '0;
        end else begin
          for (int p = 0; p < RD_PORTS; p++) begin
            if (RD_EN_taint[p])
              rd_q[p] <= '1;
            else if (RD_EN[p])
              rd_q[p] <= RD_TRANSPARENT[p] ? rd_val_tr[p] : rd_val[p];
          end
        end
      end
      assign RD_DATA_taint = rd_q;
    end
  endgenerate

`ifdef TAINTCELL_MEM_TRACE_EN
  logic             first_hit;
  logic [ABITS-1:0] first_addr;

  always_comb begin
    first_hit  = 1'b0;
    first_addr = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (!first_hit && wr_act[p] && !(|shadow[wr_idx[p]]) && (|shadow_nx[wr_idx[p]])) begin
        first_hit  = 1'b1;
        first_addr = WR_ADDR[p*ABITS +: ABITS];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      taint_first_valid <= 1'b0;
      taint_first_addr  <= '0;
    end else if (!taint_first_valid && first_hit) begin
      taint_first_valid <= 1'b1;
      taint_first_addr  <= first_addr;
    end
  end
`endif

endmodule

// File: tb/tb_taintcell_mem_tracked.sv
// tb/tb_taintcell_mem_tracked.sv - scoreboard bench for taintcell_mem_tracked (2 rd / 2 wr ports, 3 words)
module tb_taintcell_mem_tracked;
  logic        CLK;
  logic        reset;
  logic [1:0]  RD_EN, RD_EN_taint;
  logic [3:0]  RD_ADDR, RD_ADDR_taint;
  logic [15:0] RD_DATA_taint;
  logic [15:0] WR_EN, WR_EN_taint, WR_DATA_taint;
  logic [3:0]  WR_ADDR, WR_ADDR_taint;
  logic [2:0]  taint_sum;
`ifdef TAINTCELL_MEM_TRACE_EN
  logic        taint_first_valid;
  logic [1:0]  taint_first_addr;
`endif

  taintcell_mem_tracked #(
    .SIZE(3), .OFFSET(0), .ABITS(2), .WIDTH(8), .RD_PORTS(2), .WR_PORTS(2),
    .RD_LATENCY(1), .RD_TRANSPARENT(2'b01)
  ) dut (
    .CLK(CLK), .reset(reset),
    .RD_EN(RD_EN), .RD_EN_taint(RD_EN_taint), .RD_ADDR(RD_ADDR), .RD_ADDR_taint(RD_ADDR_taint),
    .RD_DATA_taint(RD_DATA_taint),
    .WR_EN(WR_EN), .WR_EN_taint(WR_EN_taint), .WR_ADDR(WR_ADDR), .WR_ADDR_taint(WR_ADDR_taint),
    .WR_DATA_taint(WR_DATA_taint), .taint_sum(taint_sum)
`ifdef TAINTCELL_MEM_TRACE_EN
    , .taint_first_valid(taint_first_valid), .taint_first_addr(taint_first_addr)
`endif
  );

  typedef struct {
    int         sel;   // 0 rd port0, 1 rd port1, 2 taint_sum, 3 trace valid, 4 trace addr
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      0: return RD_DATA_taint[7:0];
      1: return RD_DATA_taint[15:8];
      2: return {5'b0, taint_sum};
`ifdef TAINTCELL_MEM_TRACE_EN
      3: return {7'b0, taint_first_valid};
      4: return {6'b0, taint_first_addr};
`endif
      default: return 8'hxx;
    endcase
  endfunction

  task automatic idle();
    RD_EN = '0; RD_EN_taint = '0; RD_ADDR = '0; RD_ADDR_taint = '0;
    WR_EN = '0; WR_EN_taint = '0; WR_ADDR = '0; WR_ADDR_taint = '0; WR_DATA_taint = '0;
  endtask

  task automatic wr(input int p, input logic [1:0] a, input logic [7:0] en, input logic [7:0] ent,
                    input logic [7:0] d, input logic [1:0] at);
    WR_EN[p*8 +: 8] = en; WR_EN_taint[p*8 +: 8] = ent; WR_DATA_taint[p*8 +: 8] = d;
    WR_ADDR[p*2 +: 2] = a; WR_ADDR_taint[p*2 +: 2] = at;
  endtask

  task automatic rd(input int p, input logic [1:0] a, input logic en, input logic ent, input logic [1:0] at);
    RD_EN[p] = en; RD_EN_taint[p] = ent; RD_ADDR[p*2 +: 2] = a; RD_ADDR_taint[p*2 +: 2] = at;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    wr(0, 2'd1, 8'hFF, 8'h00, 8'hFF, 2'b00);
    sb.push_back('{2, 8'h00, "reset_sum"});
    sb.push_back('{0, 8'h00, "reset_rd0"});
    sb.push_back('{1, 8'h00, "reset_rd1"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); reset = 1'b0; idle(); rd(0, 2'd1, 1'b1, 1'b0, 2'b00);
    sb.push_back('{0, 8'h00, "reset_write_dropped"});
    sb.push_back('{2, 8'h00, "reset_sum_idle"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

  task automatic test_basic_write();
    @(negedge CLK); idle();
    wr(0, 2'd2, 8'hFF, 8'h00, 8'h01, 2'b00); rd(1, 2'd2, 1'b1, 1'b0, 2'b00);
    sb.push_back('{2, 8'h01, "basic_sum_rise"});
    sb.push_back('{1, 8'h00, "basic_nontransparent_prewrite"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); rd(0, 2'd2, 1'b1, 1'b0, 2'b00);
    sb.push_back('{0, 8'h01, "basic_read_back"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); wr(0, 2'd2, 8'hFF, 8'h00, 8'h00, 2'b00);
    sb.push_back('{2, 8'h00, "basic_sum_fall"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

  task automatic test_port_priority();
    @(negedge CLK); idle();
    wr(0, 2'd1, 8'hFF, 8'h00, 8'hF0, 2'b00); wr(1, 2'd1, 8'hFF, 8'h00, 8'h0F, 2'b00);
    sb.push_back('{2, 8'h01, "prio_sum_once"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); rd(1, 2'd1, 1'b1, 1'b0, 2'b00);
    sb.push_back('{1, 8'h0F, "prio_port1_wins"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

  task automatic test_en_taint();
    // memory: [00,0F,00]
    @(negedge CLK); idle(); wr(0, 2'd0, 8'h0F, 8'h00, 8'h03, 2'b00);
    sb.push_back('{2, 8'h02, "partial_en_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); wr(0, 2'd0, 8'h00, 8'h80, 8'h00, 2'b00);
    @(posedge CLK);
    @(negedge CLK); idle(); rd(0, 2'd0, 1'b1, 1'b0, 2'b00);
    wr(1, 2'd2, 8'h01, 8'h00, 8'h00, 2'b10);
    sb.push_back('{0, 8'h83, "en_taint_sets_bit"});
    sb.push_back('{2, 8'h03, "addr_taint_write_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

  task automatic test_read_taint();
    // memory: [83,0F,01]
    @(negedge CLK); idle(); rd(0, 2'd3, 1'b1, 1'b0, 2'b01); rd(1, 2'd2, 1'b1, 1'b0, 2'b00);
    sb.push_back('{0, 8'hFF, "rd_addr_taint"});
    sb.push_back('{1, 8'h01, "rd_addr_taint_write"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); rd(1, 2'd1, 1'b0, 1'b1, 2'b00); rd(0, 2'd1, 1'b0, 1'b0, 2'b00);
    sb.push_back('{1, 8'hFF, "rd_en_taint"});
    sb.push_back('{0, 8'hFF, "rd_hold"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

  task automatic test_out_of_range();
    @(negedge CLK); idle(); wr(0, 2'd3, 8'hFF, 8'h00, 8'hFF, 2'b00); rd(1, 2'd3, 1'b1, 1'b0, 2'b00);
    sb.push_back('{1, 8'hFF, "oor_read_ones"});
    sb.push_back('{2, 8'h03, "oor_write_sum_unchanged"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); rd(0, 2'd1, 1'b1, 1'b0, 2'b00);
    sb.push_back('{0, 8'h0F, "oor_neighbour_intact"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

  task automatic test_transparent();
    @(negedge CLK); idle(); wr(0, 2'd0, 8'hFF, 8'h00, 8'h00, 2'b00);
    sb.push_back('{2, 8'h02, "clean_addr0_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); wr(0, 2'd0, 8'hFF, 8'h00, 8'hAA, 2'b00);
    rd(0, 2'd0, 1'b1, 1'b0, 2'b00); rd(1, 2'd0, 1'b1, 1'b0, 2'b00);
    sb.push_back('{0, 8'hAA, "transparent_port"});
    sb.push_back('{1, 8'h00, "nontransparent_port"});
    sb.push_back('{2, 8'h03, "transparent_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

  task automatic test_back_to_back();
    // memory: [AA,0F,01]
    @(negedge CLK); idle(); wr(0, 2'd1, 8'hFF, 8'h00, 8'h00, 2'b00); wr(1, 2'd2, 8'hFF, 8'h00, 8'h00, 2'b00);
    sb.push_back('{2, 8'h01, "two_falls_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); wr(0, 2'd0, 8'hFF, 8'h00, 8'h00, 2'b00); wr(1, 2'd0, 8'hFF, 8'h00, 8'h00, 2'b00);
    sb.push_back('{2, 8'h00, "shared_fall_once"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); wr(0, 2'd1, 8'hFF, 8'h00, 8'h11, 2'b00); wr(1, 2'd1, 8'hFF, 8'h00, 8'h22, 2'b00);
    sb.push_back('{2, 8'h01, "shared_rise_once"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); rd(0, 2'd1, 1'b1, 1'b0, 2'b00);
    sb.push_back('{0, 8'h22, "shared_rise_data"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

  task automatic test_reset_mid();
    // memory: [00,22,00]
    @(negedge CLK); idle(); wr(0, 2'd0, 8'hFF, 8'h00, 8'h55, 2'b00);
    sb.push_back('{2, 8'h02, "pre_reset_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); reset = 1'b1; rd(0, 2'd0, 1'b1, 1'b0, 2'b00); wr(1, 2'd2, 8'hFF, 8'h00, 8'hFF, 2'b00);
    sb.push_back('{0, 8'h00, "reset_discards_read"});
    sb.push_back('{2, 8'h00, "reset_clears_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); reset = 1'b0; rd(0, 2'd0, 1'b1, 1'b0, 2'b00); rd(1, 2'd2, 1'b1, 1'b0, 2'b00);
    sb.push_back('{0, 8'h00, "reset_clears_shadow"});
    sb.push_back('{1, 8'h00, "reset_beats_write"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
  endtask

`ifdef TAINTCELL_MEM_TRACE_EN
  task automatic test_trace();
    @(negedge CLK); idle();
    sb.push_back('{3, 8'h00, "trace_idle_valid"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); wr(0, 2'd2, 8'hFF, 8'h00, 8'h04, 2'b00);
    @(posedge CLK);
    @(negedge CLK); idle(); wr(0, 2'd1, 8'hFF, 8'h00, 8'h08, 2'b00);
    sb.push_back('{3, 8'h01, "trace_valid"});
    sb.push_back('{4, 8'h02, "trace_first_addr"});
    sb.push_back('{2, 8'h02, "trace_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); idle(); reset = 1'b1;
    sb.push_back('{3, 8'h00, "trace_reset_valid"});
    sb.push_back('{2, 8'h00, "trace_reset_sum"});
    @(posedge CLK); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (obs(e.sel) !== e.exp) begin bad++; $display("FAIL %s: got %h want %h", e.name, obs(e.sel), e.exp); end
    end
    @(negedge CLK); reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_write();
    test_port_priority();
    test_en_taint();
    test_read_taint();
    test_out_of_range();
    test_transparent();
    test_back_to_back();
    test_reset_mid();
`ifdef TAINTCELL_MEM_TRACE_EN
    test_trace();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
